avst_frame_tx: RTL and testbench
================================

Name: avst_frame_tx

Overview:
- Avalon-ST packet transmitter that drives the sink of the FFT core.
- Captures a parallel frame of N_PTS ADC samples on a start pulse.
- Serialises the frame as one packet (sop on beat 0, eop on beat N_PTS-1), honouring src_ready backpressure.
- Double-buffered, so the sampling logic can capture the next frame while the current one is still streaming.

Parameters:
- N_PTS, 8, points per frame (power of 2, at least 2).
- DW, 12, sample width, equal to the FFT real/imag field width.
- BUS_W, 29, src_data width; must equal 2*DW+5.
- SIGNED_IN, 0, 0 = offset-binary ADC input (MSB inverted to form two's complement); 1 = input already two's complement.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous reset, active-low
- frame_start  in  1  one-cycle pulse: capture frame_data into the buffer
- frame_data  in  N_PTS x DW  unpacked array [0:N_PTS-1]; element 0 is sent first
- frame_inverse  in  1  captured with the frame, sent in data bit 0
- frame_ready  out  1  high when at least one buffer slot is free
- overflow  out  1  one-cycle pulse when frame_start arrives with both slots full
- src_valid  out  1  Avalon-ST valid
- src_ready  in  1  Avalon-ST ready, readyLatency 0
- src_sop  out  1  start of packet
- src_eop  out  1  end of packet
- src_data  out  BUS_W  [BUS_W-1 -: DW] real, next DW bits imag (always 0), [4:1] zero, [0] inverse
- src_error  out  2  constant 2'b00
- busy  out  1  high while a packet is in flight or pending

Behaviour:
- Reset: all outputs low or zero except frame_ready=1. Both slots empty, beat counter 0, state IDLE.
- Storage: two slots, ACTIVE (being streamed) and PENDING, each holding N_PTS samples plus the inverse bit.
- Beat transfer occurs when src_valid && src_ready.
- IDLE:
  - On frame_start, load the ACTIVE slot and go to SEND.
  - src_valid=1 with src_sop=1 and beat 0 on the next cycle (latency 1).
- SEND:
  - src_data = ACTIVE[beat].
  - src_sop = (beat==0); src_eop = (beat==N_PTS-1).
  - Beat increments only on transfer.
  - While src_ready=0, src_valid and data stay stable.
- Last beat transferred:
  - If PENDING is full, move it to ACTIVE in that same cycle and reset beat to 0. The next cycle presents sop of the new frame (no bubble).
  - Otherwise src_valid drops to 0 and the state returns to IDLE.
- frame_start during SEND:
  - If PENDING is empty, load PENDING.
  - If PENDING is full, drop the frame, leave existing data untouched, and pulse overflow.
- frame_start in the same cycle as the last-beat transfer with PENDING full: the promote happens first, then the new frame loads the freed PENDING slot. No overflow.
- frame_ready = !(ACTIVE full && PENDING full), registered.
- busy = (state==SEND) || PENDING full.
- Sample conversion: SIGNED_IN=0 → real = {~s[DW-1], s[DW-2:0]} (0x000 → -2048, 0xFFF → +2047). SIGNED_IN=1 → pass through.
- Reset mid-packet aborts immediately: src_valid=0 and both slots cleared. No eop is sent.

Optional Feature:
- Macro FRAME_TX_DROP_CNT_EN.
- Defined: adds output drop_count [7:0], incremented on each overflow and saturating at 255. It is cleared only by reset.
- Undefined: the port is absent and overflow is the only indication.

Decomposition:
- Package fft_if_pkg holds:
  - localparams DW, N_PTS, BUS_W
  - field offset constants REAL_LSB, IMAG_LSB, INV_BIT
  - typedef sample_t (logic signed [DW-1:0])
  - typedef frame_t (sample_t [0:N_PTS-1])
  - function pack_beat(real, inverse)
- One natural sub-module, frame_buf2: the two-slot ACTIVE/PENDING store with its full flags and promote logic. The FSM and beat counter stay in the top module.

Test Plan:
- Single frame: samples 0x000..0x007, SIGNED_IN=0, src_ready=1.
  - Required: 8 beats on consecutive cycles starting 1 cycle after frame_start.
  - Real fields 0x800..0x807; sop on beat 0, eop on beat 7; busy falls after eop.
- Backpressure: src_ready low on beats 2 and 5 for 3 cycles each.
  - Required: data, sop and eop stable while stalled; 8 beats total; eop on the 0x807 beat.
- Back-to-back: second frame_start (samples 0xFFF) during beat 3.
  - Required: the cycle after frame A's eop presents sop with real=0x7FF; no gap.
- Overflow: third frame_start while ACTIVE and PENDING are full.
  - Required: overflow pulses for 1 cycle; the third frame is never emitted; drop_count=1 when FRAME_TX_DROP_CNT_EN is defined.
- Simultaneous promote and start: frame_start on the eop-transfer cycle with PENDING full.
  - Required: no overflow; three frames emitted in order.
- Reset mid-packet: assert reset_n=0 at beat 4.
  - Required: src_valid=0 immediately and frame_ready=1.
  - After release, a new frame starts cleanly with sop on beat 0.

Source files
------------

// File: rtl/fft_if_pkg.sv
// fft_if_pkg: shared FFT sink beat layout, sample/frame types and beat packing.
package fft_if_pkg;
  localparam int DW = 12;
  localparam int N_PTS = 8;
  localparam int BUS_W = 2*DW+5;
  localparam int REAL_LSB = BUS_W-DW;
  localparam int IMAG_LSB = 5;
  localparam int INV_BIT = 0;
  typedef logic signed [DW-1:0] sample_t;
  typedef sample_t [0:N_PTS-1] frame_t;
  typedef enum logic {IDLE, SEND} tx_state_t;
  function automatic logic [BUS_W-1:0] pack_beat(sample_t re, logic inverse);
    logic [BUS_W-1:0] b;
    b = '0;
    b[REAL_LSB +: DW] = re;
    b[IMAG_LSB +: DW] = '0;
    b[INV_BIT] = inverse;
    return b;
  endfunction
endpackage

// File: rtl/frame_buf2.sv
// frame_buf2: two-slot ACTIVE/PENDING frame store with full flags and promote.
module frame_buf2 import fft_if_pkg::*; (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   load,
  input  logic   done,
  input  frame_t din,
  input  logic   din_inv,
  output frame_t act,
  output logic   act_inv,
  output logic   pend_full,
  output logic   free,
  output logic   drop
);
  frame_t pend;
  logic pend_inv, act_full, promote, act_free, pend_free, to_act, to_pend, act_full_n, pend_full_n;
  // Occupancy is judged after this cycle's promote, so a start on the last beat reuses the freed slot.
  always_comb begin
    promote = done && pend_full;
    act_free = !act_full || (done && !pend_full);
    pend_free = !pend_full || done;
    to_act = load && act_free;
    to_pend = load && !act_free && pend_free;
    drop = load && !act_free && !pend_free;
    act_full_n = to_act || promote || (act_full && !done);
    pend_full_n = to_pend || (pend_full && !done);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      act <= '0;
      act_inv <= 1'b0;
      pend <= '0;
      pend_inv <= 1'b0;
      act_full <= 1'b0;
      pend_full <= 1'b0;
      free <= 1'b1;
    end else begin
      act_full <= act_full_n;
      pend_full <= pend_full_n;
      free <= !(act_full_n && pend_full_n);
      if (to_act) begin
        act <= din;
        act_inv <= din_inv;
      end else if (promote) begin
        act <= pend;
        act_inv <= pend_inv;
      end
      if (to_pend) begin
        pend <= din;
        pend_inv <= din_inv;
      end
    end
endmodule

// File: rtl/avst_frame_tx.sv
// avst_frame_tx: double-buffered frame capture serialised as one Avalon-ST packet per frame.
// FRAME_TX_DROP_CNT_EN adds a saturating drop_count output.
module avst_frame_tx import fft_if_pkg::*; #(
  parameter int N_PTS = 8,
  parameter int DW = 12,
  parameter int BUS_W = 29,
  parameter int SIGNED_IN = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             frame_start,
  input  logic [DW-1:0]    frame_data [0:N_PTS-1],
  input  logic             frame_inverse,
  output logic             frame_ready,
  output logic             overflow,
  output logic             src_valid,
  input  logic             src_ready,
  output logic             src_sop,
  output logic             src_eop,
  output logic [BUS_W-1:0] src_data,
  output logic [1:0]       src_error,
`ifdef FRAME_TX_DROP_CNT_EN
  output logic [7:0]       drop_count,
`endif
  output logic             busy
);
  localparam int BW = $clog2(N_PTS);
  tx_state_t state, state_n;
  logic [BW-1:0] beat;
  frame_t din, act;
  sample_t s, re;
  logic act_inv, pend_full, drop, xfer, done;
  always_comb begin
    din = '0;
    for (int i = 0; i < N_PTS; i++) din[i] = frame_data[i];
  end
  frame_buf2 u_buf (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (frame_start),
    .done     (done),
    .din      (din),
    .din_inv  (frame_inverse),
    .act      (act),
    .act_inv  (act_inv),
    .pend_full(pend_full),
    .free     (frame_ready),
    .drop     (drop)
  );
  assign xfer = src_valid && src_ready;
  assign done = xfer && beat == BW'(N_PTS-1);
  assign src_error = 2'b00;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  // A start on the last beat with no pending frame goes straight into ACTIVE, so SEND continues.
  always_comb
    state_n = (state == IDLE) ? (frame_start ? SEND : IDLE)
            : ((done && !pend_full && !frame_start) ? IDLE : SEND);
  always_comb begin
    s = act[beat];
    re = (SIGNED_IN != 0) ? s : {~s[DW-1], s[DW-2:0]};
    src_valid = state == SEND;
    src_sop = src_valid && beat == '0;
    src_eop = src_valid && beat == BW'(N_PTS-1);
    src_data = src_valid ? pack_beat(re, act_inv) : '0;
    busy = src_valid || pend_full;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      beat <= '0;
      overflow <= 1'b0;
    end else begin
      beat <= done ? '0 : xfer ? beat + 1'b1 : beat;
      overflow <= drop;
    end
`ifdef FRAME_TX_DROP_CNT_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) drop_count <= '0;
    else if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
`endif
endmodule

// File: tb/tb_avst_frame_tx.sv
// tb_avst_frame_tx: directed scoreboard bench for avst_frame_tx.
module tb_avst_frame_tx;
  logic clk = 1'b0;
  logic reset_n, frame_start, frame_inverse, src_ready;
  logic [11:0] frame_data [0:7];
  logic frame_ready, overflow, src_valid, src_sop, src_eop, busy;
  logic [28:0] src_data;
  logic [1:0] src_error;
`ifdef FRAME_TX_DROP_CNT_EN
  logic [7:0] drop_count;
`endif
  typedef struct packed {logic sop; logic eop; logic [28:0] data;} beat_t;
  beat_t q[$];
  int checks = 0, fails = 0, nxfer = 0;
  logic stalled = 1'b0, gap_chk = 1'b0;
  beat_t held;

  avst_frame_tx dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .frame_start  (frame_start),
    .frame_data   (frame_data),
    .frame_inverse(frame_inverse),
    .frame_ready  (frame_ready),
    .overflow     (overflow),
    .src_valid    (src_valid),
    .src_ready    (src_ready),
    .src_sop      (src_sop),
    .src_eop      (src_eop),
    .src_data     (src_data),
    .src_error    (src_error),
`ifdef FRAME_TX_DROP_CNT_EN
    .drop_count   (drop_count),
`endif
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on every transfer, checks stall stability and gapless follow-on.
  always @(negedge clk) begin
    if (!reset_n) begin
      stalled = 1'b0;
      gap_chk = 1'b0;
    end else begin
      if (gap_chk) begin
        chk("no_gap_valid", src_valid, 1);
        chk("no_gap_sop", src_sop, 1);
      end
      gap_chk = 1'b0;
      if (stalled) begin
        chk("stall_valid", src_valid, 1);
        chk("stall_data", src_data, held.data);
        chk("stall_sop", src_sop, held.sop);
        chk("stall_eop", src_eop, held.eop);
      end
      stalled = src_valid && !src_ready;
      held = '{sop: src_sop, eop: src_eop, data: src_data};
      if (src_valid && src_ready) begin
        nxfer++;
        chk("sb_nonempty", q.size() > 0, 1);
        if (q.size() > 0) begin
          beat_t e;
          e = q.pop_front();
          chk("beat_data", src_data, e.data);
          chk("beat_sop", src_sop, e.sop);
          chk("beat_eop", src_eop, e.eop);
          gap_chk = src_eop && q.size() > 0;
        end
      end
    end
  end

  task automatic start_frame(input logic [11:0] base, input int step, input logic inv, input bit accept);
    frame_start = 1'b1;
    frame_inverse = inv;
    for (int i = 0; i < 8; i++) begin
      frame_data[i] = base + 12'(i*step);
      if (accept) q.push_back('{sop: (i == 0), eop: (i == 7),
                                data: {~frame_data[i][11], frame_data[i][10:0], 16'h0, inv}});
    end
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic wait_beats(input int base, input int n);
    int t = 0;
    while (nxfer - base < n && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("wait_beats_timeout", t < 50, 1);
  endtask

  task automatic drain();
    int t = 0;
    while ((q.size() != 0 || busy) && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_timeout", t < 100, 1);
  endtask

  initial begin
    int base, n, h2, h5, k;
    reset_n = 1'b0;
    frame_start = 1'b0;
    frame_inverse = 1'b0;
    src_ready = 1'b1;
    for (int i = 0; i < 8; i++) frame_data[i] = '0;
    repeat (2) @(negedge clk);
    chk("rst_frame_ready", frame_ready, 1);
    chk("rst_valid", src_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_data", src_data, 0);
    chk("rst_error", src_error, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Single frame, consecutive beats starting one cycle after the start pulse
    start_frame(12'h000, 1, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t1_valid", src_valid, 1);
      if (i == 0) chk("t1_first_sop", src_sop, 1);
    end
    @(negedge clk);
    chk("t1_valid_low", src_valid, 0);
    chk("t1_busy_low", busy, 0);
    chk("t1_sb_empty", q.size(), 0);
    @(posedge clk); #1;

    // Backpressure on beats 2 and 5
    base = nxfer;
    start_frame(12'h000, 1, 1'b0, 1'b1);
    n = 0; h2 = 0; h5 = 0;
    while (q.size() != 0 && n < 60) begin
      k = nxfer - base;
      if (k == 2 && h2 < 3) begin src_ready = 1'b0; h2++; end
      else if (k == 5 && h5 < 3) begin src_ready = 1'b0; h5++; end
      else src_ready = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    src_ready = 1'b1;
    chk("bp_beats", nxfer - base, 8);
    chk("bp_stalls", h2 + h5, 6);
    chk("bp_cycles", n, 14);
    drain();

    // Back-to-back: second frame started during beat 3
    base = nxfer;
    start_frame(12'h000, 1, 1'b0, 1'b1);
    wait_beats(base, 3);
    start_frame(12'hFFF, 0, 1'b1, 1'b1);
    chk("b2b_busy", busy, 1);
    drain();
    chk("b2b_beats", nxfer - base, 16);

    // Overflow: third start with both slots full is dropped
    base = nxfer;
    start_frame(12'h010, 1, 1'b0, 1'b1);
    wait_beats(base, 1);
    start_frame(12'h100, 3, 1'b1, 1'b1);
    wait_beats(base, 3);
    chk("ovf_frame_ready_low", frame_ready, 0);
    start_frame(12'h555, 0, 1'b0, 1'b0);
    @(negedge clk);
    chk("ovf_pulse", overflow, 1);
`ifdef FRAME_TX_DROP_CNT_EN
    chk("ovf_drop_count", drop_count, 1);
`endif
    @(negedge clk);
    chk("ovf_pulse_end", overflow, 0);
    drain();
    chk("ovf_beats", nxfer - base, 16);

    // Start on the eop-transfer cycle with PENDING full
    base = nxfer;
    start_frame(12'h020, 1, 1'b0, 1'b1);
    wait_beats(base, 1);
    start_frame(12'h800, 1, 1'b1, 1'b1);
    wait_beats(base, 7);
    chk("sim_at_eop", src_eop, 1);
    start_frame(12'h7F0, 2, 1'b0, 1'b1);
    @(negedge clk);
    chk("sim_no_overflow", overflow, 0);
    chk("sim_busy", busy, 1);
    @(negedge clk);
    chk("sim_no_overflow2", overflow, 0);
    drain();
    chk("sim_beats", nxfer - base, 24);
`ifdef FRAME_TX_DROP_CNT_EN
    chk("sim_drop_count", drop_count, 1);
`endif

    // Reset mid-packet at beat 4
    @(posedge clk); #1;
    base = nxfer;
    start_frame(12'h300, 1, 1'b0, 1'b1);
    wait_beats(base, 4);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_valid", src_valid, 0);
    chk("rst_mid_frame_ready", frame_ready, 1);
    chk("rst_mid_busy", busy, 0);
    q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_after_valid", src_valid, 0);
    start_frame(12'h0A0, 1, 1'b1, 1'b1);
    @(negedge clk);
    chk("rst_after_sop", src_sop, 1);
    drain();
    chk("rst_after_sb_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $fatal(1, "watchdog");
  end
endmodule
